uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single write port of `uart_tx_fifo` between several byte-stream message sources, such as `output_value_check` status reports and command-response generators. Each requester presents a packet: a byte stream terminated by a `last` flag. The arbiter grants one requester at a time, holds the grant for the whole packet, and forwards bytes into the FIFO while honouring FIFO backpressure. Default arbitration is round-robin, so no source can starve another.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width.
- `REQ_COUNT`, 2: number of requesters (2..8).
- `MAX_PACKET_LEN`, 32: watchdog limit on bytes per grant.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high reset.
- `ena` in 1: global enable. When low, all state and outputs hold.
- `req_valid` in REQ_COUNT: requester i has a byte available.
- `req_data` in REQ_COUNT*DATA_WIDTH: byte of requester i, at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in REQ_COUNT: the current byte is the final byte of the packet.
- `req_ready` out REQ_COUNT: byte accepted from requester i this cycle.
- `fifo_data` out DATA_WIDTH: byte to `uart_tx_fifo.tx_data_in`.
- `fifo_valid` out 1: write strobe to `tx_data_in_valid`.
- `fifo_full` in 1: FIFO can accept at most one more byte.
- `grant` out REQ_COUNT: one-hot current owner. All zeros when idle.
- `busy` out 1: a grant is active.
- `overrun_err` out 1: one-cycle pulse when the watchdog forces a release.

## Operation
- Reset values:
  - `grant`=0, `busy`=0, `req_ready`=0, `fifo_valid`=0, `fifo_data`=0, `overrun_err`=0.
  - State IDLE, byte count 0.
  - Round-robin pointer = REQ_COUNT-1, so requester 0 wins first.
- **IDLE state.** If any `req_valid` bit is set, select the winner by searching from pointer+1, wrapping modulo REQ_COUNT.
  - Register `grant` to the winner, set `busy`, update the pointer to the winner, clear the count, and go to STREAM.
  - If no request is present, stay in IDLE.
- **STREAM state.**
  - `req_ready[g]` = `ena` & !`fifo_full`. This is combinational; all other `req_ready` bits are 0.
  - A transfer happens when `req_valid[g]` & `req_ready[g]`.
  - On a transfer: register `fifo_data` = the byte, set `fifo_valid`=1 for exactly one cycle, and increment the count.
  - If the transferred byte has `req_last`=1: clear `grant` and `busy`, and return to IDLE.
  - Else if the count reaches MAX_PACKET_LEN: force a release exactly as above and pulse `overrun_err` in the cycle after the transfer.
- Requests on non-granted requesters are ignored during STREAM and wait for the next IDLE arbitration.
- If `req_valid[g]` drops mid-packet, the grant is held and the arbiter waits indefinitely. The watchdog counts bytes only, not idle cycles.
- **Count width.** The count is $clog2(MAX_PACKET_LEN+1) bits and saturates at its compare point; it cannot wrap.
- **Reset mid-packet.** All state clears immediately. Partially sent bytes already in the FIFO remain; the arbiter sends no completion.
- When `ena` is low, there are no transfers and no state changes. `fifo_valid` is forced to 0.

## Timing
- Grant latency: a request seen in IDLE at edge N gives `grant` valid after edge N. The first byte can transfer in cycle N+1.
- Write latency: a byte transferred in cycle T appears on `fifo_data` with `fifo_valid` in cycle T+1.
- Throughput: one byte per cycle while the FIFO is not full.
- Turnaround: the `last` byte transfers in cycle T, the arbiter is IDLE in T+1, and the next grant is active in T+2. The minimum inter-packet gap is one cycle.
- `fifo_full` is sampled in the same cycle as `req_ready`. Because the write is registered, `fifo_full` must assert while one slot is still free.
- Simultaneous requests and a pointer update resolve at one edge: the pointer always equals the index of the last granted requester.

## Configuration
- `UART_TX_ARB_FIXED_PRIORITY_EN`:
  - **Defined:** the round-robin pointer is removed, and IDLE always grants the lowest-index valid requester.
  - **Undefined (default):** round-robin as specified above.
- Everything else is identical in both builds.

## Test plan
- **Single packet.** Req0 sends 0x41, 0x42, 0x43 with `last` on 0x43 and `fifo_full`=0.
  - Expect `fifo_valid` pulses in three consecutive cycles carrying 0x41/0x42/0x43.
  - `grant`=01 for the packet, then 00.
- **Contention.** Both requesters hold 2-byte packets continuously.
  - Expect grant order 0,1,0,1, with a 1-cycle gap between packets.
  - With `UART_TX_ARB_FIXED_PRIORITY_EN`, expect grant order 0,0,0.
- **Backpressure.** Assert `fifo_full` for 4 cycles mid-packet.
  - Expect `req_ready`=0 and no `fifo_valid` during the stall.
  - The byte order is preserved after release.
- **Watchdog.** Req1 streams 40 bytes with no `last` and MAX_PACKET_LEN=32.
  - Expect exactly 32 writes, then one `overrun_err` pulse, then `grant` returns to 00 and is re-arbitrated.
- **Reset mid-packet.** Assert `reset` after 2 of 5 bytes.
  - All outputs are 0 asynchronously.
  - After release, the first grant goes to requester 0.
- **Enable freeze.** Drop `ena` for 3 cycles mid-packet.
  - No `fifo_valid`, and `grant` and the count are held.
  - The packet resumes intact.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter onto the uart_tx_fifo write port; round-robin unless UART_TX_ARB_FIXED_PRIORITY_EN (lowest index wins).
// Latency: grant 1 cycle after request, write 1 cycle after transfer; fifo_full/ena stall req_ready combinationally.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int REQ_COUNT      = 2,
    parameter int MAX_PACKET_LEN = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ena,
    input  logic [REQ_COUNT-1:0]            req_valid,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] req_data,
    input  logic [REQ_COUNT-1:0]            req_last,
    output logic [REQ_COUNT-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic                            fifo_valid,
    input  logic                            fifo_full,
    output logic [REQ_COUNT-1:0]            grant,
    output logic                            busy,
    output logic                            overrun_err
);
    localparam int CW = $clog2(MAX_PACKET_LEN + 1);
    localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PACKET_LEN);

    logic [0:0]            state_q, state_d;
    logic [REQ_COUNT-1:0]  grant_q, grant_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fvld_q, fvld_d;
    logic                  ovr_q, ovr_d;

    logic                  win_found;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         cand;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  own_last;
    logic                  xfer;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
        for (int i = REQ_COUNT - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
`else
        // gidx_q doubles as the round-robin pointer: nearest offset after it wins.
        for (int k = REQ_COUNT; k >= 1; k--) begin
            cand = IW'((int'(gidx_q) + k) % REQ_COUNT);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    always_comb begin
        own_data = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (gidx_q == IW'(i)) own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign req_ready = (state_q == S_STREAM && ena && !fifo_full) ? grant_q : '0;
    assign xfer      = |(req_valid & req_ready);
    assign own_last  = |(req_last & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fvld_d  = fvld_q;
        ovr_d   = ovr_q;
        if (ena) begin
            fvld_d = 1'b0;
            ovr_d  = 1'b0;
            if (state_q == S_IDLE) begin
                if (win_found) begin
                    state_d          = S_STREAM;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    cnt_d            = '0;
                end
            end else if (xfer) begin
                data_d = own_data;
                fvld_d = 1'b1;
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (own_last || cnt_d == CNT_MAX) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ovr_d   = !own_last;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= IW'(REQ_COUNT - 1);
            cnt_q   <= '0;
            data_q  <= '0;
            fvld_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fvld_q  <= fvld_d;
            ovr_q   <= ovr_d;
        end
    end

    // A write pending while ena is low is held and strobed once ena returns.
    assign fifo_valid  = fvld_q & ena;
    assign fifo_data   = data_q;
    assign grant       = grant_q;
    assign busy        = (state_q == S_STREAM);
    assign overrun_err = ovr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue sources, integer-level arbitration model, literal pins per scenario.
module tb_uart_tx_arbiter;
    localparam int DW   = 8;
    localparam int NR   = 2;
    localparam int MAXL = 32;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              ena       = 1'b1;
    logic              fifo_full = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last  = '0;
    logic [NR*DW-1:0]  req_data  = '0;
    logic [NR-1:0]     req_ready, grant;
    logic [DW-1:0]     fifo_data;
    logic              fifo_valid, busy, overrun_err;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .REQ_COUNT(NR), .MAX_PACKET_LEN(MAXL)) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_full(fifo_full),
        .grant(grant), .busy(busy), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    logic [DW:0]   srcq [NR][$];
    int            m_owner, m_ptr, m_cnt;
    bit            m_fv, m_ovr;
    logic [DW-1:0] m_fd;

    int            total = 0, bad = 0, cyc = 0, ovr_cnt = 0, ovr_grant = -1;
    logic [DW-1:0] obs_wr[$];
    int            wr_cyc[$];
    int            gnt_log[$];
    logic [NR-1:0] prev_grant = '0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = NR - 1; m_cnt = 0;
        m_fv = 0; m_ovr = 0; m_fd = '0;
    endtask

    task automatic clear_logs();
        obs_wr.delete(); wr_cyc.delete(); gnt_log.delete();
        ovr_cnt = 0; ovr_grant = -1;
    endtask

    task automatic push_pkt(input int r, input int base, input int len, input bit has_last);
        for (int i = 0; i < len; i++)
            srcq[r].push_back({(has_last && i == len - 1), DW'(base + i)});
    endtask

    task automatic check();
        logic [NR-1:0] eg, er;
        eg = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
        er = (m_owner >= 0 && ena && !fifo_full) ? eg : '0;
        chk("grant", int'(grant), int'(eg));
        chk("busy", int'(busy), int'(m_owner >= 0));
        chk("req_ready", int'(req_ready), int'(er));
        chk("fifo_valid", int'(fifo_valid), int'(m_fv && ena));
        if (m_fv && ena) chk("fifo_data", int'(fifo_data), int'(m_fd));
        chk("overrun_err", int'(overrun_err), int'(m_ovr));
        if (fifo_valid) begin obs_wr.push_back(fifo_data); wr_cyc.push_back(cyc); end
        if (overrun_err) begin ovr_cnt++; ovr_grant = int'(grant); end
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < NR; i++) if (grant[i]) gnt_log.push_back(i);
        prev_grant = grant;
    endtask

    // One clock edge of the arbiter's rules, in terms of owners and byte counts.
    task automatic model_step(output logic [NR-1:0] pop);
        int win;
        pop = '0;
        win = -1;
        if (!ena) return;
        m_fv = 0; m_ovr = 0;
        if (m_owner < 0) begin
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
            for (int k = NR - 1; k >= 0; k--) if (req_valid[k]) win = k;
`else
            for (int k = NR; k >= 1; k--) if (req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
`endif
            if (win >= 0) begin m_owner = win; m_ptr = win; m_cnt = 0; end
        end else if (req_valid[m_owner] && !fifo_full) begin
            m_fd = req_data[m_owner*DW +: DW];
            m_fv = 1;
            m_cnt++;
            pop[m_owner] = 1'b1;
            if (req_last[m_owner]) m_owner = -1;
            else if (m_cnt == MAXL) begin m_owner = -1; m_ovr = 1; end
        end
    endtask

    task automatic cycle();
        logic [NR-1:0] pop;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (srcq[i].size() > 0);
            req_last[i]           = req_valid[i] ? srcq[i][0][DW] : 1'b0;
            req_data[i*DW +: DW]  = req_valid[i] ? srcq[i][0][DW-1:0] : '0;
        end
        #1;
        check();
        model_step(pop);
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (pop[i]) void'(srcq[i].pop_front());
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit drained();
        bit d;
        d = (m_owner < 0) && !m_fv && !m_ovr;
        for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) d = 0;
        return d;
    endfunction

    task automatic run_idle(input string name, input int limit);
        for (int n = 0; n < limit && !drained(); n++) cycle();
        if (!drained()) chk({name, "_timeout"}, 1, 0);
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_fifo_valid", int'(fifo_valid), 0);
        chk("rst_fifo_data", int'(fifo_data), 0);
        chk("rst_overrun", int'(overrun_err), 0);
        for (int i = 0; i < NR; i++) srcq[i].delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0, n1;
        model_reset();
        #2;
        do_reset();
        cycle(); cycle();

        // Single packet from requester 0.
        clear_logs();
        c0 = cyc;
        push_pkt(0, 8'h41, 3, 1);
        run_idle("single", 20);
        chk("single_nwr", obs_wr.size(), 3);
        chk("single_b0", obs_wr.size() > 0 ? int'(obs_wr[0]) : -1, 8'h41);
        chk("single_b2", obs_wr.size() > 2 ? int'(obs_wr[2]) : -1, 8'h43);
        chk("single_first_cyc", wr_cyc.size() > 0 ? wr_cyc[0] - c0 : -1, 2);
        chk("single_consec", wr_cyc.size() > 2 ? wr_cyc[2] - wr_cyc[0] : -1, 2);
        chk("single_gnt", gnt_log.size() == 1 ? gnt_log[0] : -1, 0);

        // Contention from a fresh pointer.
        do_reset();
        clear_logs();
        for (int p = 0; p < 3; p++) push_pkt(0, 8'h10 + 2*p, 2, 1);
        for (int p = 0; p < 2; p++) push_pkt(1, 8'h20 + 2*p, 2, 1);
        run_idle("contend", 60);
        chk("contend_nwr", obs_wr.size(), 10);
        chk("contend_gap", wr_cyc.size() > 2 ? wr_cyc[2] - wr_cyc[1] : -1, 2);
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
        chk("contend_g1", gnt_log.size() > 1 ? gnt_log[1] : -1, 0);
        chk("contend_g2", gnt_log.size() > 2 ? gnt_log[2] : -1, 0);
        chk("contend_g3", gnt_log.size() > 3 ? gnt_log[3] : -1, 1);
        chk("contend_w2", obs_wr.size() > 2 ? int'(obs_wr[2]) : -1, 8'h12);
`else
        chk("contend_g1", gnt_log.size() > 1 ? gnt_log[1] : -1, 1);
        chk("contend_g2", gnt_log.size() > 2 ? gnt_log[2] : -1, 0);
        chk("contend_g3", gnt_log.size() > 3 ? gnt_log[3] : -1, 1);
        chk("contend_w2", obs_wr.size() > 2 ? int'(obs_wr[2]) : -1, 8'h20);
`endif
        chk("contend_g0", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // Backpressure: four stalled cycles mid-packet.
        clear_logs();
        push_pkt(0, 8'h60, 6, 1);
        repeat (3) cycle();
        fifo_full = 1'b1;
        repeat (4) cycle();
        chk("stall_no_write", obs_wr.size(), 2);
        fifo_full = 1'b0;
        run_idle("stall", 20);
        chk("stall_nwr", obs_wr.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("stall_order", obs_wr.size() > i ? int'(obs_wr[i]) : -1, 8'h60 + i);

        // Enable freeze: three cycles with ena low mid-packet.
        clear_logs();
        push_pkt(0, 8'h90, 6, 1);
        repeat (3) cycle();
        ena = 1'b0;
        repeat (3) cycle();
        chk("freeze_no_write", obs_wr.size(), 1);
        chk("freeze_grant", int'(grant), 1);
        ena = 1'b1;
        run_idle("freeze", 20);
        chk("freeze_nwr", obs_wr.size(), 6);
        chk("freeze_b5", obs_wr.size() > 5 ? int'(obs_wr[5]) : -1, 8'h95);

        // Watchdog: 40 bytes without last.
        clear_logs();
        push_pkt(1, 8'h80, 40, 0);
        for (int n = 0; n < 60 && ovr_cnt == 0; n++) cycle();
        chk("wd_nwr", obs_wr.size(), 32);
        chk("wd_grant_at_ovr", ovr_grant, 0);
        chk("wd_last_byte", obs_wr.size() > 31 ? int'(obs_wr[31]) : -1, 8'h9F);
        repeat (3) cycle();
        chk("wd_ovr_cnt", ovr_cnt, 1);
        chk("wd_regrant", gnt_log.size() == 2 ? gnt_log[1] : -1, 1);

        // Reset mid-packet on requester 0, leaving the pointer at 0 beforehand.
        do_reset();
        clear_logs();
        push_pkt(0, 8'h70, 5, 1);
        for (int n = 0; n < 10 && obs_wr.size() < 2; n++) cycle();
        chk("rmid_before", obs_wr.size(), 2);
        do_reset();
        clear_logs();
        push_pkt(0, 8'hA0, 2, 1);
        push_pkt(1, 8'hB0, 2, 1);
        run_idle("rmid", 30);
        chk("rmid_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        chk("rmid_first_byte", obs_wr.size() > 0 ? int'(obs_wr[0]) : -1, 8'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
